// File: rtl/dedicated_processor_accum.sv
// Frame accumulator: sums NUM_SAMPLES unsigned samples taken over a valid/ready
// input, then holds the sum and a sticky carry flag on a valid/ready output.
module dedicated_processor_accum #(
  parameter int DATA_W      = 8,
  parameter int SUM_W       = 16,
  parameter int NUM_SAMPLES = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SUM_W-1:0]  sum_out,
  output logic              sum_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  // state    | meaning
  // S_CLEAR  | one cycle: zero acc/cnt/ovf, nothing accepted or presented
  // S_ACCUM  | accept one sample per in_valid cycle until NUM_SAMPLES taken
  // S_DONE   | present acc/ovf until out_ready

  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SAMPLES - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [SUM_W:0]   sum_ext;

  // One extra bit captures the carry out of the accumulator.
  assign sum_ext = {1'b0, acc} + (SUM_W+1)'(in_data);

  assign sum_out = acc;
  assign sum_ovf = ovf;

  // in_ready/out_valid are registered alongside the state so no input reaches
  // an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_CLEAR;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          acc      <= '0;
          cnt      <= '0;
          ovf      <= 1'b0;
          state    <= S_ACCUM;
          in_ready <= 1'b1;
        end
        S_ACCUM: begin
          if (in_valid) begin
            acc <= sum_ext[SUM_W-1:0];
            ovf <= ovf | sum_ext[SUM_W];
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state     <= S_DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_CLEAR;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_CLEAR;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dedicated_processor_accum.sv
// Bench for dedicated_processor_accum: three configurations (default, 8-bit
// sum, single-sample frames) checked against a frame-level sum model.
module tb_dedicated_processor_accum;

  logic       clk;
  logic [2:0] rst;
  logic [2:0] in_valid;
  logic [2:0] out_ready;
  wire  [2:0] in_ready;
  wire  [2:0] out_valid;
  wire  [2:0] sum_ovf;
  logic [7:0] in_data [3];
  wire  [15:0] sum0;
  wire  [7:0]  sum1;
  wire  [15:0] sum2;
  wire  [15:0] sum_v [3];

  int checks;
  int errors;

  assign sum_v[0] = sum0;
  assign sum_v[1] = {8'h00, sum1};
  assign sum_v[2] = sum2;

  dedicated_processor_accum #(.DATA_W(8), .SUM_W(16), .NUM_SAMPLES(10)) u_dut0 (
    .clk(clk), .rst(rst[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .sum_out(sum0), .sum_ovf(sum_ovf[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]));

  dedicated_processor_accum #(.DATA_W(8), .SUM_W(8), .NUM_SAMPLES(10)) u_dut1 (
    .clk(clk), .rst(rst[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .sum_out(sum1), .sum_ovf(sum_ovf[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]));

  dedicated_processor_accum #(.DATA_W(8), .SUM_W(16), .NUM_SAMPLES(1)) u_dut2 (
    .clk(clk), .rst(rst[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .sum_out(sum2), .sum_ovf(sum_ovf[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int nsamp(input int d);
    return (d == 2) ? 1 : 10;
  endfunction

  function automatic int sumw(input int d);
    return (d == 1) ? 8 : 16;
  endfunction

  // Hold dut d in reset for two cycles, check reset outputs, release at negedge.
  task automatic reset_dut(input int d);
    rst[d] = 1'b1;
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0 || sum_v[d] !== 16'd0 || sum_ovf[d] !== 1'b0) begin
      errors++;
      $display("FAIL reset_values dut%0d: in_ready=%b out_valid=%b sum=%0d ovf=%b, expected 0 0 0 0",
               d, in_ready[d], out_valid[d], sum_v[d], sum_ovf[d]);
    end
    rst[d] = 1'b0;
  endtask

  // One whole frame, entered at the negedge of the clear cycle.
  // mode: 0 = 1..N, 1 = random, 2 = all cval.  first >= 0 overrides sample 0.
  // gap: 0 = continuous, 1 = toggling valid, 2 = random valid.
  // bp: cycles out_ready is held low once the result is up.
  // hold >= 0: value offered (and not consumed) while the result is presented.
  task automatic frame(input int d, input int mode, input int cval, input int first,
                       input int gap, input int bp, input int hold);
    int     n;
    int     w;
    int     samples[$];
    longint total;
    longint mask;
    int     i;
    bit     v;
    bit     tog;
    logic [15:0] exp_sum;
    bit     exp_ovf;
    n = nsamp(d);
    w = sumw(d);
    total = 0;
    for (int j = 0; j < n; j++) begin
      int s;
      case (mode)
        0:       s = j + 1;
        1:       s = int'($urandom_range(0, 255));
        default: s = cval;
      endcase
      if (j == 0 && first >= 0) s = first;
      samples.push_back(s);
      total += s;
    end
    mask = (longint'(1) << w) - 1;
    exp_sum = 16'(total & mask);
    exp_ovf = (total > mask);

    checks++;
    if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0) begin
      errors++;
      $display("FAIL clear_cycle dut%0d: in_ready=%b out_valid=%b, expected 0 0",
               d, in_ready[d], out_valid[d]);
    end
    in_valid[d] = 1'b1;
    in_data[d] = 8'(samples[0]);
    out_ready[d] = 1'($urandom_range(0, 1));
    @(negedge clk);

    i = 0;
    tog = 1'b1;
    while (i < n) begin
      checks++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
        errors++;
        $display("FAIL accum_phase dut%0d sample %0d: in_ready=%b out_valid=%b, expected 1 0",
                 d, i, in_ready[d], out_valid[d]);
      end
      case (gap)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      in_valid[d] = v;
      in_data[d] = v ? 8'(samples[i]) : 8'($urandom_range(0, 255));
      out_ready[d] = 1'($urandom_range(0, 1));
      if (v) i++;
      @(negedge clk);
    end

    in_valid[d] = (hold >= 0);
    in_data[d] = (hold >= 0) ? 8'(hold) : 8'($urandom_range(0, 255));
    for (int k = 0; k <= bp; k++) begin
      checks++;
      if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0 || sum_v[d] !== exp_sum || sum_ovf[d] !== 1'(exp_ovf)) begin
        errors++;
        $display("FAIL result dut%0d cycle %0d: out_valid=%b in_ready=%b sum=%0d ovf=%b, expected 1 0 %0d %b",
                 d, k, out_valid[d], in_ready[d], sum_v[d], sum_ovf[d], exp_sum, exp_ovf);
      end
      out_ready[d] = (k == bp);
      @(negedge clk);
    end
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 3'b111;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0 || sum_v[d] !== 16'd0 || sum_ovf[d] !== 1'b0) begin
        errors++;
        $display("FAIL power_on_reset dut%0d: in_ready=%b out_valid=%b sum=%0d ovf=%b, expected 0 0 0 0",
                 d, in_ready[d], out_valid[d], sum_v[d], sum_ovf[d]);
      end
    end
  endtask

  task automatic test_basic();
    reset_dut(0);
    frame(0, 0, 0, -1, 0, 0, -1);
  endtask

  task automatic test_gaps();
    frame(0, 0, 0, -1, 1, 0, -1);
  endtask

  task automatic test_backpressure();
    frame(0, 0, 0, -1, 0, 5, 7);
    frame(0, 0, 0, 7, 0, 0, -1);
  endtask

  task automatic test_random();
    repeat (6) frame(0, 1, 0, -1, 2, int'($urandom_range(0, 3)), -1);
  endtask

  task automatic test_overflow();
    reset_dut(1);
    frame(1, 2, 255, -1, 0, 0, -1);
    frame(1, 2, 1, -1, 0, 0, -1);
    repeat (4) frame(1, 1, 0, -1, 2, int'($urandom_range(0, 2)), -1);
  endtask

  task automatic test_reset_mid();
    reset_dut(0);
    in_valid[0] = 1'b1;
    in_data[0] = 8'd1;
    @(negedge clk);
    for (int j = 1; j <= 4; j++) begin
      in_data[0] = 8'(j);
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    checks++;
    if (sum_v[0] !== 16'd10 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL partial_sum: sum=%0d in_ready=%b, expected 10 1", sum_v[0], in_ready[0]);
    end
    #3 rst[0] = 1'b1;
    #1;
    checks++;
    if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b0 || sum_v[0] !== 16'd0 || sum_ovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_mid: in_ready=%b out_valid=%b sum=%0d ovf=%b, expected 0 0 0 0",
               in_ready[0], out_valid[0], sum_v[0], sum_ovf[0]);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    frame(0, 0, 0, -1, 0, 0, -1);
  endtask

  task automatic test_single();
    reset_dut(2);
    repeat (4) frame(2, 2, 200, -1, 0, 0, -1);
    repeat (4) frame(2, 1, 0, -1, 2, int'($urandom_range(0, 2)), -1);
    // Reset while the result is being presented.
    in_valid[2] = 1'b1;
    in_data[2] = 8'd200;
    out_ready[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_valid[2] = 1'b0;
    checks++;
    if (out_valid[2] !== 1'b1 || sum_v[2] !== 16'd200) begin
      errors++;
      $display("FAIL single_done: out_valid=%b sum=%0d, expected 1 200", out_valid[2], sum_v[2]);
    end
    #2 rst[2] = 1'b1;
    #1;
    checks++;
    if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b0 || sum_v[2] !== 16'd0) begin
      errors++;
      $display("FAIL async_reset_done: out_valid=%b in_ready=%b sum=%0d, expected 0 0 0",
               out_valid[2], in_ready[2], sum_v[2]);
    end
    @(negedge clk);
    rst[2] = 1'b0;
    frame(2, 2, 200, -1, 0, 0, -1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 3'b111;
    in_valid = 3'b000;
    out_ready = 3'b000;
    for (int d = 0; d < 3; d++) in_data[d] = 8'd0;
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_random();
    test_overflow();
    test_reset_mid();
    test_single();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
